branch_predict_unit: RTL
========================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, data/address width.
REQ-002 The module SHALL have parameter BHT_DEPTH, default 64, number of 2-bit counters; power of two and at least 4.
REQ-003 The module SHALL have parameter CNT_INIT, default 2'b01, counter value after reset (weakly not-taken).
REQ-004 The module SHALL have parameter SQUASH_CYCLES, default 1, cycles after a redirect during which valid_i is ignored; range 1..7.
REQ-005 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_i  input  1  reset; asynchronous, active-high.
REQ-007 fetch_pc_i  input  XLEN  fetch-stage PC for prediction lookup.
REQ-008 pred_taken_o  output  1  predicted direction for fetch_pc_i.
REQ-009 valid_i  input  1  resolve request this cycle.
REQ-010 stall_i  input  1  pipeline stall; freezes all state.
REQ-011 bus_i  input  core::pipeline_bus_t  pc, imm, alu_op, is_branch of the resolving instruction.
REQ-012 pred_taken_i, pred_target_i  input  1, XLEN  prediction carried with the instruction from fetch.
REQ-013 rs1_in_i, rs2_in_i  input  XLEN  forwarded operands.
REQ-014 redirect_o, redirect_pc_o  output  1, XLEN  registered misprediction redirect.
REQ-015 br_bus_o  output  core::br_cntrl_bus_t  registered is_taken, branch_target, i_addr.
REQ-016 rd_o, rd_we_o  output  XLEN, 1  registered link value (PC+4) and write enable for JAL/JALR.

Function
REQ-017 Index SHALL be pc[$clog2(BHT_DEPTH)+1:2]; pred_taken_o SHALL be bit 1 of the counter at fetch_pc_i's index, combinationally.
REQ-018 Outcome SHALL be: BEQ/BNE equality, BLT/BGE signed, BLTU/BGEU unsigned compare; JAL/JALR always taken.
REQ-019 Target SHALL be pc+imm for branches and JAL, and (rs1+imm) with bit 0 cleared for JALR; all sums SHALL be modulo 2^XLEN.
REQ-020 An accepted resolve SHALL occur when valid_i=1, bus_i.is_branch=1, stall_i=0 and the squash counter is zero.
REQ-021 Mispredict SHALL be (taken != pred_taken_i) OR (taken AND target != pred_target_i).
REQ-022 Redirect target SHALL be the computed target if taken, else pc+4.
REQ-023 All outputs except pred_taken_o SHALL be registered, with one-cycle latency from the accepted resolve.
REQ-024 The FSM SHALL have two states. RUN: a mispredict SHALL load the squash counter with SQUASH_CYCLES and go to SQUASH. SQUASH: requests SHALL be ignored; the counter SHALL decrement on each unstalled cycle; at 1 the FSM SHALL return to RUN.
REQ-025 redirect_o SHALL pulse for exactly one unstalled cycle per mispredict; without an accepted resolve, redirect_o, rd_we_o and br_bus_o.is_taken SHALL be 0 next cycle.
REQ-026 Only accepted conditional branches SHALL update the BHT: saturating increment if taken, decrement if not; saturate at 3 and 0. Jumps SHALL NOT update it.
REQ-027 Same-index lookup and update in one cycle SHALL return the pre-update value.
REQ-028 While stall_i=1, registered outputs, FSM, squash counter and BHT SHALL hold.

Reset
REQ-029 Asserting rst_i SHALL immediately set every BHT counter to CNT_INIT, the FSM to RUN, the squash counter to 0, and all registered outputs to 0, including mid-SQUASH or mid-stall.

Configuration
REQ-030 With BRANCH_STATS_EN defined, outputs br_count_o and mispred_count_o (32 bits each, wrapping) SHALL count accepted resolves and mispredicts, and SHALL reset to 0.
REQ-031 Without BRANCH_STATS_EN, those ports and counters SHALL be absent.

Structure
REQ-032 Package core SHALL hold bht_cnt_t (2-bit) and the weak/strong counter constants; BHT_DEPTH SHALL stay a module parameter.
REQ-033 The counter array with its read and update port SHALL be sub-module branch_bht.

Verification
REQ-034 The bench SHALL cover these scenarios:
- After reset, any fetch_pc_i -> pred_taken_o=0.
- BEQ at pc 0x100, rs1=rs2=5, pred_taken_i=0 -> next cycle redirect_o=1, redirect_pc_o=0x100+imm. Counter at idx 0x100[7:2] goes 01->10, so pred_taken_o=1 for fetch_pc_i=0x100.
- Same BEQ with pred_taken_i=1 and correct target -> redirect_o=0. With SQUASH_CYCLES=2 after a mispredict, the next 2 valid_i pulses are ignored.
- JALR rs1=0x2003, imm=4, pred_taken_i=1, pred_target_i=0x2000 -> redirect_pc_o=0x2006, rd_o=pc+4, rd_we_o=1, BHT unchanged.
- BLT rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU with the same operands -> not taken. Four taken updates -> counter saturates at 3.
- stall_i high for 3 cycles during SQUASH -> outputs hold. rst_i asserted mid-SQUASH -> outputs 0 asynchronously. With BRANCH_STATS_EN, counts match the stimulus.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// Package core: shared types for the branch predict unit.
// Holds the 2-bit BHT counter type, its weak/strong constants, the
// resolve-side pipeline bus and the branch control bus.
package core;

  // Width of address/data fields carried on the shared pipeline buses.
  localparam int BUS_XLEN = 32;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t CNT_STRONG_NT = 2'b00;
  localparam bht_cnt_t CNT_WEAK_NT   = 2'b01;
  localparam bht_cnt_t CNT_WEAK_T    = 2'b10;
  localparam bht_cnt_t CNT_STRONG_T  = 2'b11;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_BEQ  = 4'd1,
    ALU_BNE  = 4'd2,
    ALU_BLT  = 4'd3,
    ALU_BGE  = 4'd4,
    ALU_BLTU = 4'd5,
    ALU_BGEU = 4'd6,
    ALU_JAL  = 4'd7,
    ALU_JALR = 4'd8
  } alu_op_t;

  typedef struct packed {
    logic [BUS_XLEN-1:0] pc;
    logic [BUS_XLEN-1:0] imm;
    alu_op_t             alu_op;
    logic                is_branch;
  } pipeline_bus_t;

  typedef struct packed {
    logic                is_taken;
    logic [BUS_XLEN-1:0] branch_target;
    logic [BUS_XLEN-1:0] i_addr;
  } br_cntrl_bus_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } bpu_state_t;

  // Saturating 2-bit counter step: up on taken, down on not-taken.
  function automatic bht_cnt_t sat_update(input bht_cnt_t cnt, input logic taken);
    bht_cnt_t res;
    if (taken) begin
      res = (cnt == CNT_STRONG_T) ? cnt : cnt + 2'b01;
    end else begin
      res = (cnt == CNT_STRONG_NT) ? cnt : cnt - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_predict_unit_bht.sv
// branch_bht: array of 2-bit saturating counters with one combinational
// read port (fetch lookup) and one synchronous update port (resolve).
// A same-index read and update in one cycle returns the pre-update value.
module branch_bht
  import core::*;
#(
  parameter int       DEPTH    = 64,
  parameter bht_cnt_t CNT_INIT = 2'b01
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output bht_cnt_t                 rd_cnt,
  input  logic                     upd_en,
  input  logic [$clog2(DEPTH)-1:0] upd_idx,
  input  logic                     upd_taken
);

  bht_cnt_t cnt_r [DEPTH];

  // Counter storage: async reset to CNT_INIT, saturating update on resolve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_r[i] <= CNT_INIT;
      end
    end else if (upd_en) begin
      cnt_r[upd_idx] <= sat_update(cnt_r[upd_idx], upd_taken);
    end
  end

  assign rd_cnt = cnt_r[rd_idx];

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: BHT-based direction predictor plus branch resolve.
// Resolves branches/jumps, registers redirect, control-bus and link outputs,
// and squashes requests for SQUASH_CYCLES unstalled cycles after a redirect.
// Optional feature macro: BRANCH_STATS_EN adds br_count_o/mispred_count_o.
// XLEN must not exceed core::BUS_XLEN.
module branch_predict_unit
  import core::*;
#(
  parameter int       XLEN          = 32,
  parameter int       BHT_DEPTH     = 64,
  parameter bht_cnt_t CNT_INIT      = 2'b01,
  parameter int       SQUASH_CYCLES = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [XLEN-1:0]     fetch_pc_i,
  output logic                pred_taken_o,
  input  logic                valid_i,
  input  logic                stall_i,
  input  core::pipeline_bus_t bus_i,
  input  logic                pred_taken_i,
  input  logic [XLEN-1:0]     pred_target_i,
  input  logic [XLEN-1:0]     rs1_in_i,
  input  logic [XLEN-1:0]     rs2_in_i,
  output logic                redirect_o,
  output logic [XLEN-1:0]     redirect_pc_o,
  output core::br_cntrl_bus_t br_bus_o,
  output logic [XLEN-1:0]     rd_o,
  output logic                rd_we_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]         br_count_o,
  output logic [31:0]         mispred_count_o
`endif
);

  localparam int         IDX_W       = $clog2(BHT_DEPTH);
  localparam logic [2:0] SQUASH_LOAD = 3'(SQUASH_CYCLES);

  logic [XLEN-1:0] pc_s, imm_s, pc_plus4_s, br_sum_s, jalr_sum_s;
  logic [XLEN-1:0] target_s, redirect_tgt_s;
  logic            taken_s, is_cond_s, is_jump_s;
  logic            accept_s, mispredict_s;
  bht_cnt_t        pred_cnt_s;
  logic            unused_s;

  bpu_state_t      state_r, state_s;
  logic [2:0]      squash_cnt_r, squash_cnt_s;

  logic            redirect_r;
  logic [XLEN-1:0] redirect_pc_r;
  br_cntrl_bus_t   br_bus_r;
  logic [XLEN-1:0] rd_r;
  logic            rd_we_r;

  assign pc_s       = bus_i.pc[XLEN-1:0];
  assign imm_s      = bus_i.imm[XLEN-1:0];
  assign pc_plus4_s = pc_s + XLEN'(32'd4);
  assign br_sum_s   = pc_s + imm_s;
  assign jalr_sum_s = rs1_in_i + imm_s;
  assign unused_s   = ^{fetch_pc_i[XLEN-1:IDX_W+2], fetch_pc_i[1:0], jalr_sum_s[0]};

  // Direction, class and target of the resolving instruction.
  always_comb begin
    taken_s   = 1'b0;
    is_cond_s = 1'b0;
    is_jump_s = 1'b0;
    target_s  = br_sum_s;
    case (bus_i.alu_op)
      ALU_BEQ:  begin is_cond_s = 1'b1; taken_s = (rs1_in_i == rs2_in_i); end
      ALU_BNE:  begin is_cond_s = 1'b1; taken_s = (rs1_in_i != rs2_in_i); end
      ALU_BLT:  begin is_cond_s = 1'b1; taken_s = ($signed(rs1_in_i) < $signed(rs2_in_i)); end
      ALU_BGE:  begin is_cond_s = 1'b1; taken_s = ($signed(rs1_in_i) >= $signed(rs2_in_i)); end
      ALU_BLTU: begin is_cond_s = 1'b1; taken_s = (rs1_in_i < rs2_in_i); end
      ALU_BGEU: begin is_cond_s = 1'b1; taken_s = (rs1_in_i >= rs2_in_i); end
      ALU_JAL:  begin is_jump_s = 1'b1; taken_s = 1'b1; end
      ALU_JALR: begin
        is_jump_s = 1'b1;
        taken_s   = 1'b1;
        target_s  = {jalr_sum_s[XLEN-1:1], 1'b0};
      end
      default:  begin taken_s = 1'b0; end
    endcase
  end

  assign accept_s       = valid_i & bus_i.is_branch & ~stall_i & (squash_cnt_r == 3'd0);
  assign mispredict_s   = (taken_s != pred_taken_i) | (taken_s & (target_s != pred_target_i));
  assign redirect_tgt_s = taken_s ? target_s : pc_plus4_s;

  branch_bht #(
    .DEPTH    (BHT_DEPTH),
    .CNT_INIT (CNT_INIT)
  ) u_bht (
    .clk       (clk_i),
    .rst       (rst_i),
    .rd_idx    (fetch_pc_i[IDX_W+1:2]),
    .rd_cnt    (pred_cnt_s),
    .upd_en    (accept_s & is_cond_s),
    .upd_idx   (pc_s[IDX_W+1:2]),
    .upd_taken (taken_s)
  );

  assign pred_taken_o = pred_cnt_s[1];

  // FSM state and squash counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= ST_RUN;
      squash_cnt_r <= 3'd0;
    end else begin
      state_r      <= state_s;
      squash_cnt_r <= squash_cnt_s;
    end
  end

  // Next state: enter SQUASH on mispredict, count down unstalled cycles.
  always_comb begin
    state_s      = state_r;
    squash_cnt_s = squash_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (accept_s && mispredict_s) begin
          state_s      = ST_SQUASH;
          squash_cnt_s = SQUASH_LOAD;
        end else begin
          state_s      = ST_RUN;
        end
      end
      ST_SQUASH: begin
        if (stall_i) begin
          state_s      = ST_SQUASH;
        end else if (squash_cnt_r <= 3'd1) begin
          state_s      = ST_RUN;
          squash_cnt_s = 3'd0;
        end else begin
          state_s      = ST_SQUASH;
          squash_cnt_s = squash_cnt_r - 3'd1;
        end
      end
      default: begin
        state_s      = ST_RUN;
        squash_cnt_s = 3'd0;
      end
    endcase
  end

  // Registered resolve outputs; strobes clear without an accepted resolve.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      redirect_r    <= 1'b0;
      redirect_pc_r <= '0;
      br_bus_r      <= '0;
      rd_r          <= '0;
      rd_we_r       <= 1'b0;
    end else if (!stall_i) begin
      redirect_r        <= accept_s & mispredict_s;
      br_bus_r.is_taken <= accept_s & taken_s;
      rd_we_r           <= accept_s & is_jump_s;
      if (accept_s) begin
        redirect_pc_r          <= redirect_tgt_s;
        br_bus_r.branch_target <= BUS_XLEN'(target_s);
        br_bus_r.i_addr        <= BUS_XLEN'(pc_s);
        rd_r                   <= pc_plus4_s;
      end
    end
  end

  assign redirect_o    = redirect_r;
  assign redirect_pc_o = redirect_pc_r;
  assign br_bus_o      = br_bus_r;
  assign rd_o          = rd_r;
  assign rd_we_o       = rd_we_r;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count_r, mispred_count_r;

  // Wrapping counts of accepted resolves and mispredicts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_count_r      <= 32'd0;
      mispred_count_r <= 32'd0;
    end else if (accept_s) begin
      br_count_r <= br_count_r + 32'd1;
      if (mispredict_s) begin
        mispred_count_r <= mispred_count_r + 32'd1;
      end
    end
  end

  assign br_count_o      = br_count_r;
  assign mispred_count_o = mispred_count_r;
`endif

endmodule
